// File: rtl/sb_pkg.sv
// Shared definitions for the functional-unit scoreboard: default sizes,
// the "no producer" tag, per-FU state encoding and tag/index helpers.
package sb_pkg;

  localparam int NUM_FU_DEF   = 3;
  localparam int NUM_REGS_DEF = 32;
  localparam int TAG_NONE     = 0;

  typedef enum logic {
    FU_IDLE = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  // Tags are 1-based so that 0 can mean "operand already in the RF".
  function automatic int tag_of(input int fu_idx);
    return fu_idx + 1;
  endfunction

  function automatic int idx_of(input int tag);
    return tag - 1;
  endfunction

endpackage

// File: rtl/sb_fu_slot.sv
// One functional-unit slot of the scoreboard: holds busy/rd/wr for an
// in-flight instruction and derives free, writeback enable and spurious-done.
module sb_fu_slot
  import sb_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              done_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              wr_i,
  output fu_state_e         state_o,
  output logic              busy_o,
  output logic              free_o,
  output logic              retire_o,
  output logic              wb_en_o,
  output logic              spurious_o,
  output logic [REG_AW-1:0] rd_o
);

  fu_state_e         state_q;
  logic [REG_AW-1:0] rd_q;
  logic              wr_q;

  // load_i is only raised when the slot is free, so a load in BUSY implies
  // the current instruction is completing this very cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FU_IDLE;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        FU_IDLE: begin
          if (load_i) begin
            state_q <= FU_BUSY;
            rd_q    <= rd_i;
            wr_q    <= wr_i;
          end
        end
        FU_BUSY: begin
          if (load_i) begin
            rd_q <= rd_i;
            wr_q <= wr_i;
          end else if (done_i) begin
            state_q <= FU_IDLE;
          end
        end
      endcase
    end
  end

  assign state_o    = state_q;
  assign busy_o     = (state_q == FU_BUSY);
  assign free_o     = !busy_o || done_i;
  assign retire_o   = done_i && busy_o;
  assign wb_en_o    = retire_o && wr_q;
  assign spurious_o = done_i && !busy_o;
  assign rd_o       = rd_q;

endmodule

// File: rtl/fu_scoreboard.sv
// Scoreboard for in-order issue / out-of-order completion over NUM_FU units.
// Optional macro SB_BYPASS_EN: same-cycle wakeup of source tags on fu_done.
module fu_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_FU   = NUM_FU_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int TAG_W    = $clog2(NUM_FU + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_fu,
  input  logic [REG_AW-1:0]        issue_rs1,
  input  logic [REG_AW-1:0]        issue_rs2,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic                     issue_wr,
  output logic                     stall,
  output logic [NUM_FU-1:0]        fu_load,
  output logic [TAG_W-1:0]         src1_tag,
  output logic [TAG_W-1:0]         src2_tag,
  input  logic [NUM_FU-1:0]        fu_done,
  output logic [NUM_FU*REG_AW-1:0] wb_rd,
  output logic [NUM_FU-1:0]        wb_en,
  output logic [NUM_FU-1:0]        fu_busy,
  output logic                     idle,
  output logic                     err
);

  localparam logic [TAG_W-1:0] TAG0     = TAG_W'(TAG_NONE);
  localparam logic [TAG_W-1:0] NUM_FU_T = TAG_W'(NUM_FU);

  logic [TAG_W-1:0]  owner_q [NUM_REGS];
  logic [TAG_W-1:0]  owner_d [NUM_REGS];
  logic              err_q;
  logic              err_d;

  logic [NUM_FU-1:0] free_v;
  logic [NUM_FU-1:0] retire_v;
  logic [NUM_FU-1:0] spurious_v;
  logic [REG_AW-1:0] slot_rd [NUM_FU];
  fu_state_e         slot_state [NUM_FU];

  logic              fu_ok;
  logic              sel_free;
  logic [TAG_W-1:0]  rd_owner;
  logic              waw;
  logic              fire;

  // True when tag t names an FU whose bit is set in v; tag 0 never matches.
  function automatic logic tag_hit(input logic [TAG_W-1:0] t,
                                   input logic [NUM_FU-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (t == TAG_W'(tag_of(k))) hit = v[k];
    end
    return hit;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_FU; g++) begin : g_slot
      sb_fu_slot #(.REG_AW(REG_AW)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (fu_load[g]),
        .done_i     (fu_done[g]),
        .rd_i       (issue_rd),
        .wr_i       (issue_wr),
        .state_o    (slot_state[g]),
        .busy_o     (fu_busy[g]),
        .free_o     (free_v[g]),
        .retire_o   (retire_v[g]),
        .wb_en_o    (wb_en[g]),
        .spurious_o (spurious_v[g]),
        .rd_o       (slot_rd[g])
      );
      assign wb_rd[g*REG_AW +: REG_AW] = slot_rd[g];
    end
  endgenerate

  assign fu_ok    = (issue_fu < NUM_FU_T);
  assign rd_owner = owner_q[issue_rd];
  // A producer finishing this cycle no longer blocks a new writer of rd.
  assign waw      = issue_wr && (issue_rd != '0) && (rd_owner != TAG0) &&
                    !tag_hit(rd_owner, fu_done);

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (issue_fu == TAG_W'(k)) sel_free = free_v[k];
    end
  end

  assign fire  = issue_valid && fu_ok && sel_free && !waw;
  assign stall = issue_valid && !fire;

  always_comb begin
    fu_load = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_load[k] = fire && (issue_fu == TAG_W'(k));
    end
  end

  always_comb begin
    src1_tag = TAG0;
    src2_tag = TAG0;
    if (issue_rs1 != '0) src1_tag = owner_q[issue_rs1];
    if (issue_rs2 != '0) src2_tag = owner_q[issue_rs2];
`ifdef SB_BYPASS_EN
    if (tag_hit(src1_tag, fu_done)) src1_tag = TAG0;
    if (tag_hit(src2_tag, fu_done)) src2_tag = TAG0;
`endif
  end

  // Retirements clear first so a same-cycle issue to the same rd wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) owner_d[r] = owner_q[r];
    for (int k = 0; k < NUM_FU; k++) begin
      if (retire_v[k] && (owner_q[slot_rd[k]] == TAG_W'(tag_of(k)))) begin
        owner_d[slot_rd[k]] = TAG0;
      end
    end
    if (fire && issue_wr && (issue_rd != '0)) begin
      owner_d[issue_rd] = issue_fu + TAG_W'(1);
    end
  end

  assign err_d = err_q || (|spurious_v) || (issue_valid && !fu_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= TAG0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= owner_d[r];
      err_q <= err_d;
    end
  end

  assign err  = err_q;
  assign idle = ~|fu_busy;

endmodule

// File: tb/tb_fu_scoreboard.sv
// Self-checking bench for fu_scoreboard (NUM_FU=3, NUM_REGS=32); honours
// SB_BYPASS_EN for the expected source-tag wakeup timing.
module tb_fu_scoreboard;

  localparam int NF = 3;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          issue_valid = 1'b0;
  logic [TW-1:0] issue_fu = '0;
  logic [AW-1:0] issue_rs1 = '0;
  logic [AW-1:0] issue_rs2 = '0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_wr = 1'b0;
  logic [NF-1:0] fu_done = '0;
  logic          stall;
  logic [NF-1:0] fu_load;
  logic [TW-1:0] src1_tag;
  logic [TW-1:0] src2_tag;
  logic [NF*AW-1:0] wb_rd;
  logic [NF-1:0] wb_en;
  logic [NF-1:0] fu_busy;
  logic          idle;
  logic          err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model: who owns each register, what each FU holds.
  int m_own  [NR] = '{default: 0};
  bit m_busy [NF] = '{default: 1'b0};
  int m_rd   [NF] = '{default: 0};
  bit m_wr   [NF] = '{default: 1'b0};
  bit m_err = 1'b0;

  fu_scoreboard #(.NUM_FU(NF), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_wr(issue_wr), .stall(stall), .fu_load(fu_load),
    .src1_tag(src1_tag), .src2_tag(src2_tag), .fu_done(fu_done),
    .wb_rd(wb_rd), .wb_en(wb_en), .fu_busy(fu_busy), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fire();
    int f;
    int o;
    bit waw;
    f = int'(issue_fu);
    o = m_own[issue_rd];
    waw = issue_wr && (issue_rd != 0) && (o != 0) && !fu_done[o-1];
    if (!issue_valid || f >= NF || waw) return 1'b0;
    return !m_busy[f] || fu_done[f];
  endfunction

  function automatic int m_src(input int rs);
    int t;
    if (rs == 0) return 0;
    t = m_own[rs];
`ifdef SB_BYPASS_EN
    if (t != 0 && fu_done[t-1]) return 0;
`endif
    return t;
  endfunction

  function automatic logic [AW-1:0] wbrd(input int k);
    return wb_rd[k*AW +: AW];
  endfunction

  // Model state advance, applying the retire-then-issue rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) m_own[r] <= 0;
      for (int k = 0; k < NF; k++) begin
        m_busy[k] <= 1'b0;
        m_rd[k]   <= 0;
        m_wr[k]   <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      for (int k = 0; k < NF; k++) begin
        if (fu_done[k] && m_busy[k]) begin
          if (m_own[m_rd[k]] == k + 1) m_own[m_rd[k]] <= 0;
          if (!(m_fire() && int'(issue_fu) == k)) m_busy[k] <= 1'b0;
        end else if (fu_done[k]) begin
          m_err <= 1'b1;
        end
      end
      if (issue_valid && int'(issue_fu) >= NF) m_err <= 1'b1;
      if (m_fire()) begin
        m_busy[issue_fu] <= 1'b1;
        m_rd[issue_fu]   <= int'(issue_rd);
        m_wr[issue_fu]   <= issue_wr;
        if (issue_wr && issue_rd != 0) m_own[issue_rd] <= int'(issue_fu) + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NF-1:0] e_load;
      logic [NF-1:0] e_busy;
      logic [NF-1:0] e_wb;
      e_load = '0;
      e_busy = '0;
      e_wb   = '0;
      if (m_fire()) e_load[issue_fu] = 1'b1;
      for (int k = 0; k < NF; k++) begin
        e_busy[k] = m_busy[k];
        e_wb[k]   = fu_done[k] && m_busy[k] && m_wr[k];
        if (m_busy[k]) check("m_wb_rd", 32'(wbrd(k)), 32'(m_rd[k]));
      end
      check("m_stall", 32'(stall), 32'(issue_valid && !m_fire()));
      check("m_fu_load", 32'(fu_load), 32'(e_load));
      check("m_src1", 32'(src1_tag), 32'(m_src(int'(issue_rs1))));
      check("m_src2", 32'(src2_tag), 32'(m_src(int'(issue_rs2))));
      check("m_wb_en", 32'(wb_en), 32'(e_wb));
      check("m_busy", 32'(fu_busy), 32'(e_busy));
      check("m_idle", 32'(idle), 32'(e_busy == '0));
      check("m_err", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc(input bit v, input int fu, input int rs1, input int rs2,
                     input int rd, input bit wr, input logic [NF-1:0] done);
    @(posedge clk);
    #1;
    issue_valid = v;
    issue_fu    = TW'(fu);
    issue_rs1   = AW'(rs1);
    issue_rs2   = AW'(rs2);
    issue_rd    = AW'(rd);
    issue_wr    = wr;
    fu_done     = done;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    issue_valid = 1'b0;
    fu_done = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_busy", 32'(fu_busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // RAW through FU0 -> FU1
    cyc(1, 0, 0, 0, 5, 1, 3'b000);
    check("raw_load0", 32'(fu_load), 32'b001);
    cyc(1, 1, 5, 0, 6, 1, 3'b000);
    check("raw_src1", 32'(src1_tag), 32'd1);
    check("raw_nostall", 32'(stall), 32'd0);
    cyc(0, 0, 5, 0, 0, 0, 3'b001);
    check("raw_wb_en", 32'(wb_en), 32'b001);
    check("raw_wb_rd", 32'(wbrd(0)), 32'd5);
`ifdef SB_BYPASS_EN
    check("raw_bypass", 32'(src1_tag), 32'd0);
`else
    check("raw_nobypass", 32'(src1_tag), 32'd1);
`endif
    cyc(0, 0, 5, 0, 0, 0, 3'b000);
    check("raw_cleared", 32'(src1_tag), 32'd0);

    // WAW on r7
    cyc(1, 0, 0, 0, 7, 1, 3'b000);
    cyc(1, 2, 0, 0, 7, 1, 3'b000);
    check("waw_stall0", 32'(stall), 32'd1);
    cyc(1, 2, 0, 0, 7, 1, 3'b000);
    check("waw_stall1", 32'(stall), 32'd1);
    cyc(1, 2, 0, 0, 7, 1, 3'b001);
    check("waw_fire", 32'(stall), 32'd0);
    check("waw_load", 32'(fu_load), 32'b100);
    cyc(0, 0, 7, 0, 0, 0, 3'b000);
    check("waw_owner3", 32'(src1_tag), 32'd3);

    // Structural on FU1 with same-cycle release
    cyc(1, 1, 0, 0, 9, 1, 3'b000);
    check("str_stall", 32'(stall), 32'd1);
    cyc(1, 1, 0, 0, 9, 1, 3'b010);
    check("str_fire", 32'(fu_load), 32'b010);
    check("str_wb_rd_old", 32'(wbrd(1)), 32'd6);
    cyc(0, 0, 9, 6, 0, 0, 3'b000);
    check("str_busy", 32'(fu_busy), 32'b110);
    check("str_wb_rd_new", 32'(wbrd(1)), 32'd9);
    check("str_src_new", 32'(src1_tag), 32'd2);
    check("str_src_old", 32'(src2_tag), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 3'b110);
    check("multi_wb_en", 32'(wb_en), 32'b110);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_err", 32'(err), 32'd0);

    // x0 destination twice
    cyc(1, 0, 0, 0, 0, 1, 3'b000);
    check("x0_a", 32'(stall), 32'd0);
    cyc(1, 1, 0, 7, 0, 1, 3'b000);
    check("x0_b", 32'(stall), 32'd0);
    check("x0_rs0", 32'(src1_tag), 32'd0);
    check("x0_r7", 32'(src2_tag), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 3'b011);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    check("x0_idle", 32'(idle), 32'd1);

    // Spurious completion
    cyc(0, 0, 0, 0, 0, 0, 3'b100);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    check("spur_err", 32'(err), 32'd1);

    // Illegal FU index
    pulse_reset();
    check("rst2_err", 32'(err), 32'd0);
    cyc(1, 3, 0, 0, 4, 1, 3'b000);
    check("ill_stall", 32'(stall), 32'd1);
    check("ill_load", 32'(fu_load), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    check("ill_err", 32'(err), 32'd1);

    // Reset while an instruction is in flight and another is presented
    pulse_reset();
    cyc(1, 0, 0, 0, 12, 1, 3'b000);
    @(posedge clk);
    #1;
    issue_valid = 1'b1; issue_fu = 2'd1; issue_rs1 = 5'd12; issue_rd = 5'd13;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(fu_busy), 32'd0);
    check("mid_idle", 32'(idle), 32'd1);
    check("mid_owner", 32'(src1_tag), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 12, 0, 0, 0, 3'b001);
    check("late_wb_en", 32'(wb_en), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    check("late_err", 32'(err), 32'd1);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
